// File: rtl/spi_burst_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : spi_burst_ctrl
//  Brief    : TX/RX byte FIFOs and chip-select burst framing for the SPI master
//  Revision : 1.0
// ============================================================================
module spi_burst_ctrl #(
    parameter int FIFO_DEPTH = 8,
    parameter int CS_SETUP   = 2,
    parameter int CS_HOLD    = 2
) (
    input  logic       P_clk,
    input  logic       reset,
    input  logic [7:0] i_WR_DATA,
    input  logic       i_WR_LAST,
    input  logic       i_WR_VALID,
    output logic       o_WR_READY,
    output logic [7:0] o_RD_DATA,
    output logic       o_RD_VALID,
    input  logic       i_RD_READY,
    output logic       o_RX_OVERFLOW,
    output logic [7:0] o_TX_DATA,
    output logic       o_TX_DV,
    input  logic       i_TX_READY,
    input  logic [7:0] i_RX_DATA,
    input  logic       i_RX_DV,
    output logic       o_CS_n,
    output logic       o_BUSY
);

    localparam int c_ADDR_W  = $clog2(FIFO_DEPTH);
    localparam int c_CNT_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    localparam logic [c_ADDR_W:0]  c_PTR_ONE    = 1;
    localparam logic [c_CNT_W-1:0] c_CNT_ONE    = 1;
    localparam logic [c_CNT_W-1:0] c_CNT_ZERO   = 0;
    localparam logic [c_CNT_W-1:0] c_SETUP_LOAD = CS_SETUP - 1;
    // HOLD runs one cycle longer than its load so CS rises CS_HOLD+1 edges after completion
    localparam logic [c_CNT_W-1:0] c_HOLD_LOAD  = CS_HOLD;

    localparam logic [2:0] c_ST_IDLE      = 3'd0;
    localparam logic [2:0] c_ST_SETUP     = 3'd1;
    localparam logic [2:0] c_ST_ISSUE     = 3'd2;
    localparam logic [2:0] c_ST_WAIT_ACK  = 3'd3;
    localparam logic [2:0] c_ST_WAIT_DONE = 3'd4;
    localparam logic [2:0] c_ST_HOLD      = 3'd5;

    // TX FIFO: {last, data}
    logic [8:0]        r_tx_mem [FIFO_DEPTH];
    logic [c_ADDR_W:0] r_tx_wptr;
    logic [c_ADDR_W:0] r_tx_rptr;
    logic              w_tx_empty;
    logic              w_tx_full;
    logic              w_tx_push;
    logic              w_tx_pop;
    logic [8:0]        w_tx_head;

    // RX FIFO
    logic [7:0]        r_rx_mem [FIFO_DEPTH];
    logic [c_ADDR_W:0] r_rx_wptr;
    logic [c_ADDR_W:0] r_rx_rptr;
    logic              w_rx_empty;
    logic              w_rx_full;
    logic              w_rx_write;
    logic              w_rx_push;
    logic              w_rx_pop;

    // FSM
    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               r_cs_n;
    logic               w_cs_n_nxt;
    logic               r_tx_dv;
    logic               w_tx_dv_nxt;
    logic [7:0]         r_tx_data;
    logic [7:0]         w_tx_data_nxt;
    logic               r_last;
    logic               w_last_nxt;
    logic               r_rx_ovf;

    assign w_tx_empty = (r_tx_wptr == r_tx_rptr);
    assign w_tx_full  = (r_tx_wptr[c_ADDR_W] != r_tx_rptr[c_ADDR_W]) &&
                        (r_tx_wptr[c_ADDR_W-1:0] == r_tx_rptr[c_ADDR_W-1:0]);
    assign o_WR_READY = ~reset & ~w_tx_full;
    assign w_tx_push  = i_WR_VALID & o_WR_READY;
    assign w_tx_head  = r_tx_mem[r_tx_rptr[c_ADDR_W-1:0]];

    always_ff @(posedge P_clk) begin
        if (w_tx_push) begin
            r_tx_mem[r_tx_wptr[c_ADDR_W-1:0]] <= {i_WR_LAST, i_WR_DATA};
        end
    end

    always_ff @(posedge P_clk) begin
        if (reset) begin
            r_tx_wptr <= '0;
            r_tx_rptr <= '0;
        end else begin
            if (w_tx_push) begin
                r_tx_wptr <= r_tx_wptr + c_PTR_ONE;
            end
            if (w_tx_pop) begin
                r_tx_rptr <= r_tx_rptr + c_PTR_ONE;
            end
        end
    end

    assign w_rx_empty = (r_rx_wptr == r_rx_rptr);
    assign w_rx_full  = (r_rx_wptr[c_ADDR_W] != r_rx_rptr[c_ADDR_W]) &&
                        (r_rx_wptr[c_ADDR_W-1:0] == r_rx_rptr[c_ADDR_W-1:0]);
    // Fullness is judged before any same-cycle pop, so a full FIFO always drops
    assign w_rx_write = i_RX_DV & ~r_cs_n;
    assign w_rx_push  = w_rx_write & ~w_rx_full;
    assign w_rx_pop   = i_RD_READY & ~w_rx_empty;

    always_ff @(posedge P_clk) begin
        if (w_rx_push) begin
            r_rx_mem[r_rx_wptr[c_ADDR_W-1:0]] <= i_RX_DATA;
        end
    end

    always_ff @(posedge P_clk) begin
        if (reset) begin
            r_rx_wptr <= '0;
            r_rx_rptr <= '0;
            r_rx_ovf  <= 1'b0;
        end else begin
            r_rx_ovf <= w_rx_write & w_rx_full;
            if (w_rx_push) begin
                r_rx_wptr <= r_rx_wptr + c_PTR_ONE;
            end
            if (w_rx_pop) begin
                r_rx_rptr <= r_rx_rptr + c_PTR_ONE;
            end
        end
    end

    assign o_RD_VALID    = ~w_rx_empty;
    assign o_RD_DATA     = w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rptr[c_ADDR_W-1:0]];
    assign o_RX_OVERFLOW = r_rx_ovf;

    always_ff @(posedge P_clk) begin
        if (reset) begin
            r_state   <= c_ST_IDLE;
            r_cnt     <= '0;
            r_cs_n    <= 1'b1;
            r_tx_dv   <= 1'b0;
            r_tx_data <= 8'h00;
            r_last    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_cs_n    <= w_cs_n_nxt;
            r_tx_dv   <= w_tx_dv_nxt;
            r_tx_data <= w_tx_data_nxt;
            r_last    <= w_last_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_cs_n_nxt    = r_cs_n;
        w_tx_dv_nxt   = 1'b0;
        w_tx_data_nxt = r_tx_data;
        w_last_nxt    = r_last;
        w_tx_pop      = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (!w_tx_empty && i_TX_READY) begin
                    w_cs_n_nxt  = 1'b0;
                    w_cnt_nxt   = c_SETUP_LOAD;
                    w_state_nxt = c_ST_SETUP;
                end
            end
            c_ST_SETUP: begin
                if (r_cnt == c_CNT_ZERO) begin
                    w_state_nxt = c_ST_ISSUE;
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                end
            end
            c_ST_ISSUE: begin
                if (i_TX_READY && !w_tx_empty) begin
                    w_tx_pop      = 1'b1;
                    w_tx_dv_nxt   = 1'b1;
                    w_tx_data_nxt = w_tx_head[7:0];
                    w_last_nxt    = w_tx_head[8];
                    w_state_nxt   = c_ST_WAIT_ACK;
                end
            end
            c_ST_WAIT_ACK: begin
                if (!i_TX_READY) begin
                    w_state_nxt = c_ST_WAIT_DONE;
                end
            end
            c_ST_WAIT_DONE: begin
                // Without a last flag an empty FIFO leaves CS low until more data arrives
                if (i_TX_READY) begin
                    if (r_last) begin
                        w_cnt_nxt   = c_HOLD_LOAD;
                        w_state_nxt = c_ST_HOLD;
                    end else if (!w_tx_empty) begin
                        w_tx_pop      = 1'b1;
                        w_tx_dv_nxt   = 1'b1;
                        w_tx_data_nxt = w_tx_head[7:0];
                        w_last_nxt    = w_tx_head[8];
                        w_state_nxt   = c_ST_WAIT_ACK;
                    end
                end
            end
            c_ST_HOLD: begin
                if (r_cnt == c_CNT_ZERO) begin
                    w_cs_n_nxt  = 1'b1;
                    w_state_nxt = c_ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                end
            end
            default: begin
                w_cs_n_nxt  = 1'b1;
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    assign o_CS_n    = r_cs_n;
    assign o_TX_DV   = r_tx_dv;
    assign o_TX_DATA = r_tx_data;
    assign o_BUSY    = (r_state != c_ST_IDLE) | ~w_tx_empty;

endmodule
`default_nettype wire

// File: tb/tb_spi_burst_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_burst_ctrl
//  Brief    : Scoreboard bench for spi_burst_ctrl with a behavioural SPI master
//  Revision : 1.0
// ============================================================================
module tb_spi_burst_ctrl;

    localparam int DEPTH = 8;
    localparam int SETUP = 2;
    localparam int HOLD  = 2;

    logic       P_clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] i_WR_DATA = 8'h00;
    logic       i_WR_LAST = 1'b0;
    logic       i_WR_VALID = 1'b0;
    logic       o_WR_READY;
    logic [7:0] o_RD_DATA;
    logic       o_RD_VALID;
    logic       i_RD_READY = 1'b0;
    logic       o_RX_OVERFLOW;
    logic [7:0] o_TX_DATA;
    logic       o_TX_DV;
    logic       i_TX_READY = 1'b1;
    logic [7:0] i_RX_DATA = 8'h00;
    logic       i_RX_DV = 1'b0;
    logic       o_CS_n;
    logic       o_BUSY;

    always #5 P_clk = ~P_clk;

    spi_burst_ctrl #(.FIFO_DEPTH(DEPTH), .CS_SETUP(SETUP), .CS_HOLD(HOLD)) dut (
        .P_clk(P_clk), .reset(reset),
        .i_WR_DATA(i_WR_DATA), .i_WR_LAST(i_WR_LAST), .i_WR_VALID(i_WR_VALID),
        .o_WR_READY(o_WR_READY),
        .o_RD_DATA(o_RD_DATA), .o_RD_VALID(o_RD_VALID), .i_RD_READY(i_RD_READY),
        .o_RX_OVERFLOW(o_RX_OVERFLOW),
        .o_TX_DATA(o_TX_DATA), .o_TX_DV(o_TX_DV), .i_TX_READY(i_TX_READY),
        .i_RX_DATA(i_RX_DATA), .i_RX_DV(i_RX_DV),
        .o_CS_n(o_CS_n), .o_BUSY(o_BUSY)
    );

    typedef struct {
        logic [7:0] d;
        bit         last;
        int         w;
    } tx_t;

    tx_t        exp_tx[$];
    logic [7:0] exp_rx[$];
    int checks = 0;
    int errors = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endfunction

    function automatic int imax(int a, int b);
        return (a > b) ? a : b;
    endfunction

    // Behavioural SPI master: drops ready on DV, returns a byte after a random time
    int         m_busy = 0;
    bit         m_hold = 0;
    logic [7:0] rx_next = 8'h40;
    initial begin
        forever begin
            @(posedge P_clk);
            #2;
            i_RX_DV = 1'b0;
            if (reset) begin
                i_TX_READY = 1'b1;
                m_busy = 0;
            end else if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) begin
                    i_TX_READY = 1'b1;
                    i_RX_DV = 1'b1;
                    i_RX_DATA = rx_next;
                    rx_next = rx_next + 8'h01;
                end
            end else if (o_TX_DV) begin
                i_TX_READY = 1'b0;
                m_busy = $urandom_range(2, 6);
            end else begin
                i_TX_READY = !m_hold;
            end
        end
    end

    // Host read side: 0 = never pop, 1 = random, 2 = always
    int rd_mode = 2;
    initial begin
        forever begin
            @(posedge P_clk);
            #1;
            case (rd_mode)
                0:       i_RD_READY = 1'b0;
                1:       i_RD_READY = ($urandom_range(0, 3) != 0);
                default: i_RD_READY = 1'b1;
            endcase
        end
    end

    // Monitor / scoreboard
    int   cyc = 0;
    logic p_dv = 1'b0, p_cs = 1'b1, p_rdy = 1'b1;
    bit   rst_prev = 1'b1;
    bit   first_in_burst = 1'b1, last_pending = 1'b0, exp_ovf = 1'b0;
    int   cs_fall_cyc = 0, last_cs_rise = 0, r_rise = 0, exp_cs_rise = -1;
    int   dv_total = 0, cs_falls = 0, cs_rises = 0, ovf_seen = 0;

    always @(negedge P_clk) begin
        cyc++;
        if (reset) begin
            chk("wr_ready_in_reset", o_WR_READY, 0);
            exp_tx.delete();
            exp_rx.delete();
            exp_ovf = 1'b0;
            first_in_burst = 1'b1;
            last_pending = 1'b0;
            exp_cs_rise = -1;
            rst_prev = 1'b1;
            p_dv = 1'b0;
            p_cs = 1'b1;
            p_rdy = i_TX_READY;
        end else begin
            if (rst_prev) begin
                chk("rst_cs_n", o_CS_n, 1);
                chk("rst_tx_dv", o_TX_DV, 0);
                chk("rst_tx_data", o_TX_DATA, 0);
                chk("rst_rd_data", o_RD_DATA, 0);
                chk("rst_ovf", o_RX_OVERFLOW, 0);
                last_cs_rise = cyc;
                rst_prev = 1'b0;
            end
            if (i_TX_READY && !p_rdy) begin
                r_rise = cyc;
                if (last_pending) begin
                    exp_cs_rise = cyc + HOLD + 2;
                    last_pending = 1'b0;
                end
            end
            if (!o_CS_n && p_cs) begin
                cs_falls++;
                first_in_burst = 1'b1;
                cs_fall_cyc = cyc;
                if (exp_tx.size() == 0) chk("cs_fall_with_data", 0, 1);
                else chk("cs_fall_time", cyc,
                         imax(imax(exp_tx[0].w + 2, last_cs_rise + 1), r_rise + 1));
            end
            if (o_CS_n && !p_cs) begin
                cs_rises++;
                chk("cs_rise_time", cyc, exp_cs_rise);
                last_cs_rise = cyc;
                exp_cs_rise = -1;
            end
            if (o_TX_DV) begin
                tx_t e;
                dv_total++;
                chk("dv_while_cs_low", o_CS_n, 0);
                chk("dv_not_consecutive", p_dv, 0);
                if (exp_tx.size() == 0) begin
                    chk("dv_expected", 0, 1);
                end else begin
                    e = exp_tx.pop_front();
                    chk("tx_data", o_TX_DATA, e.d);
                    if (first_in_burst) chk("first_dv_time", cyc, cs_fall_cyc + SETUP + 1);
                    else chk("next_dv_time", cyc, imax(r_rise + 1, e.w + 2));
                    last_pending = e.last;
                end
                first_in_burst = 1'b0;
            end
            chk("wr_ready", o_WR_READY, exp_tx.size() < DEPTH);
            chk("busy", o_BUSY, (!o_CS_n) || (exp_tx.size() > 0));
            if (i_WR_VALID && exp_tx.size() < DEPTH) begin
                tx_t n;
                n.d = i_WR_DATA;
                n.last = i_WR_LAST;
                n.w = cyc;
                exp_tx.push_back(n);
            end
            begin
                bit full_before;
                chk("rd_valid", o_RD_VALID, exp_rx.size() > 0);
                if (o_RD_VALID && exp_rx.size() > 0) chk("rd_data", o_RD_DATA, exp_rx[0]);
                chk("rx_overflow", o_RX_OVERFLOW, exp_ovf);
                if (o_RX_OVERFLOW) ovf_seen++;
                exp_ovf = 1'b0;
                full_before = (exp_rx.size() == DEPTH);
                if (i_RD_READY && exp_rx.size() > 0) void'(exp_rx.pop_front());
                if (i_RX_DV && !o_CS_n) begin
                    if (full_before) exp_ovf = 1'b1;
                    else exp_rx.push_back(i_RX_DATA);
                end
            end
            p_dv = o_TX_DV;
            p_cs = o_CS_n;
            p_rdy = i_TX_READY;
        end
    end

    task automatic wr(input logic [7:0] d, input bit l);
        int  n;
        bit  ok;
        n = 0;
        @(posedge P_clk);
        #1;
        i_WR_VALID = 1'b1;
        i_WR_DATA = d;
        i_WR_LAST = l;
        forever begin
            @(negedge P_clk);
            ok = o_WR_READY;
            @(posedge P_clk);
            if (ok) break;
            n++;
            if (n > 2000) begin
                chk("wr_timeout", 0, 1);
                break;
            end
        end
        #1;
        i_WR_VALID = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        forever begin
            @(negedge P_clk);
            #1;
            if (exp_tx.size() == 0 && o_CS_n && !o_BUSY && i_TX_READY) break;
            n++;
            if (n > 3000) begin
                chk("idle_timeout", 0, 1);
                break;
            end
        end
        repeat (2) @(posedge P_clk);
    endtask

    task automatic drain_rx();
        int n;
        n = 0;
        rd_mode = 2;
        forever begin
            @(negedge P_clk);
            #1;
            if (exp_rx.size() == 0 && !o_RD_VALID) break;
            n++;
            if (n > 200) begin
                chk("drain_timeout", 0, 1);
                break;
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int b_dv, b_fall, b_rise, b_ovf, len;
        repeat (3) @(posedge P_clk);
        #3;
        reset = 1'b0;
        repeat (3) @(posedge P_clk);

        // Single-byte burst
        b_dv = dv_total; b_fall = cs_falls;
        wr(8'hA5, 1'b1);
        wait_idle();
        chk("single_dv_count", dv_total - b_dv, 1);
        chk("single_cs_windows", cs_falls - b_fall, 1);

        // Three-byte burst
        b_dv = dv_total; b_fall = cs_falls;
        wr(8'h01, 1'b0);
        wr(8'h02, 1'b0);
        wr(8'h03, 1'b1);
        wait_idle();
        chk("three_dv_count", dv_total - b_dv, 3);
        chk("three_cs_windows", cs_falls - b_fall, 1);

        // Underrun
        b_dv = dv_total; b_rise = cs_rises;
        wr(8'h11, 1'b0);
        repeat (50) @(posedge P_clk);
        @(negedge P_clk);
        chk("underrun_cs_low", o_CS_n, 0);
        chk("underrun_no_rise", cs_rises - b_rise, 0);
        wr(8'h22, 1'b1);
        wait_idle();
        chk("underrun_dv_count", dv_total - b_dv, 2);
        chk("underrun_one_rise", cs_rises - b_rise, 1);
        drain_rx();

        // TX full: master held off so nothing drains
        m_hold = 1'b1;
        repeat (2) @(posedge P_clk);
        b_dv = dv_total;
        for (int i = 0; i < DEPTH; i++) wr(8'hC0 + 8'(i), i == DEPTH - 1);
        @(negedge P_clk);
        chk("full_wr_ready", o_WR_READY, 0);
        @(posedge P_clk);
        #1;
        i_WR_VALID = 1'b1;
        i_WR_DATA = 8'hFF;
        i_WR_LAST = 1'b1;
        repeat (5) @(posedge P_clk);
        #1;
        i_WR_VALID = 1'b0;
        chk("full_no_dv_while_held", dv_total - b_dv, 0);
        m_hold = 1'b0;
        wait_idle();
        chk("full_dv_count", dv_total - b_dv, DEPTH);
        drain_rx();

        // RX overflow
        rd_mode = 0;
        rx_next = 8'h80;
        b_ovf = ovf_seen;
        for (int i = 0; i < 10; i++) wr(8'h50 + 8'(i), i == 9);
        wait_idle();
        chk("ovf_pulses", ovf_seen - b_ovf, 2);
        @(negedge P_clk);
        chk("ovf_rd_head", o_RD_DATA, 8'h80);
        drain_rx();

        // Reset mid-burst while byte 2 of 4 is awaiting acknowledge
        m_hold = 1'b1;
        repeat (2) @(posedge P_clk);
        b_dv = dv_total;
        wr(8'h31, 1'b0);
        wr(8'h32, 1'b0);
        wr(8'h33, 1'b0);
        wr(8'h34, 1'b1);
        m_hold = 1'b0;
        begin
            int n;
            n = 0;
            forever begin
                @(negedge P_clk);
                #1;
                if (dv_total - b_dv >= 2) break;
                n++;
                if (n > 500) begin
                    chk("reset_wait_timeout", 0, 1);
                    break;
                end
            end
        end
        reset = 1'b1;
        @(posedge P_clk);
        #1;
        chk("midrst_cs_n", o_CS_n, 1);
        chk("midrst_tx_dv", o_TX_DV, 0);
        chk("midrst_busy", o_BUSY, 0);
        chk("midrst_rd_valid", o_RD_VALID, 0);
        @(posedge P_clk);
        #3;
        reset = 1'b0;
        repeat (2) @(posedge P_clk);
        b_dv = dv_total;
        wr(8'h5A, 1'b1);
        wait_idle();
        chk("post_reset_dv_count", dv_total - b_dv, 1);
        drain_rx();

        // Randomized bursts with random host read pressure
        rd_mode = 1;
        for (int b = 0; b < 12; b++) begin
            len = $urandom_range(1, 5);
            for (int i = 0; i < len; i++) wr(8'($urandom), i == len - 1);
            repeat ($urandom_range(0, 6)) @(posedge P_clk);
        end
        wait_idle();
        drain_rx();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
